// File: rtl/mem_resp.sv
// MEM-stage data-RAM response: waits for the RAM ack, stalls, then aligns and extends load data.
// Optional watchdog is enabled with `define MEM_RESP_TIMEOUT_EN.
`ifndef WD_RAM
`define WD_RAM 2'b01
`endif
`ifndef RAM_EXT_B
`define RAM_EXT_B  3'd0
`define RAM_EXT_BU 3'd1
`define RAM_EXT_H  3'd2
`define RAM_EXT_HU 3'd3
`define RAM_EXT_W  3'd4
`endif

module mem_resp #(
  parameter int TO_CYCLES = 255,
  parameter int TO_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [1:0]  mem_wd_sel,
  input  logic [31:0] mem_ram_addr,
  input  logic [2:0]  mem_ram_ext_op,
  input  logic [3:0]  mem_ram_we,
  input  logic        da_rvalid,
  input  logic [31:0] da_rdata,
  input  logic        da_wdone,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [31:0] wb_rdata,
  output logic        mem_ale,
  output logic        mem_timeout
);
  typedef enum logic [2:0] {IDLE, WAIT_R, WAIT_W, DONE, ERR} state_t;

  state_t      state, nstate;
  logic        start, is_st, is_word, is_half, misal, waiting, ack, tmo;
  logic [1:0]  off_q;
  logic [2:0]  ext_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  assign start   = mem_valid & (mem_wd_sel == `WD_RAM);
  assign is_st   = |mem_ram_we;
  // Stores size by byte enables, loads by extension code.
  assign is_word = is_st ? (mem_ram_we == 4'hF) : (mem_ram_ext_op == `RAM_EXT_W);
  assign is_half = is_st ? (mem_ram_we == 4'h3)
                         : (mem_ram_ext_op == `RAM_EXT_H) || (mem_ram_ext_op == `RAM_EXT_HU);
  assign misal   = (is_word & |mem_ram_addr[1:0]) | (is_half & mem_ram_addr[0]);
  assign waiting = (state == WAIT_R) || (state == WAIT_W);
  assign ack     = ((state == WAIT_R) & da_rvalid) | ((state == WAIT_W) & da_wdone);

`ifdef MEM_RESP_TIMEOUT_EN
  logic [TO_W-1:0] cnt;
  // A same-cycle ack takes priority over the watchdog.
  assign tmo = waiting & ~ack & (cnt == TO_W'(TO_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (!waiting) cnt <= '0;
    else if (!ack)    cnt <= cnt + TO_W'(1);
  end
  logic unused_in;
  assign unused_in = ^mem_ram_addr[31:2];
`else
  assign tmo = 1'b0;
  logic unused_in;
  assign unused_in = ^{mem_ram_addr[31:2], TO_CYCLES, TO_W};
`endif

  always_comb begin
    nstate    = state;
    mem_stall = 1'b0;
    case (state)
      IDLE, DONE: begin
        nstate    = IDLE;
        mem_stall = start & ~misal;
        if (start) nstate = misal ? ERR : (is_st ? WAIT_W : WAIT_R);
      end
      WAIT_R: begin
        mem_stall = 1'b1;
        if (da_rvalid | tmo) nstate = DONE;
      end
      WAIT_W: begin
        mem_stall = 1'b1;
        if (da_wdone | tmo) nstate = DONE;
      end
      ERR:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    byte_sel = da_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? da_rdata[31:16] : da_rdata[15:0];
    case (ext_q)
      `RAM_EXT_B:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      `RAM_EXT_BU: ext_data = {24'h0, byte_sel};
      `RAM_EXT_H:  ext_data = {{16{half_sel[15]}}, half_sel};
      `RAM_EXT_HU: ext_data = {16'h0, half_sel};
      default:     ext_data = da_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wb_valid    <= 1'b0;
      wb_rdata    <= '0;
      mem_ale     <= 1'b0;
      mem_timeout <= 1'b0;
      off_q       <= '0;
      ext_q       <= '0;
    end else begin
      state       <= nstate;
      wb_valid    <= (nstate == DONE) || (nstate == ERR);
      mem_ale     <= (nstate == ERR);
      mem_timeout <= tmo;
      if (nstate == DONE)
        wb_rdata <= ((state == WAIT_R) && da_rvalid) ? ext_data : 32'h0;
      else if (nstate == ERR)
        wb_rdata <= 32'h0;
      if (start && ((state == IDLE) || (state == DONE))) begin
        off_q <= mem_ram_addr[1:0];
        ext_q <= mem_ram_ext_op;
      end
    end
  end
endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp: expected {timeout, ale, rdata} queued at issue, popped at wb_valid.
module tb_mem_resp;
  localparam logic [1:0] WD_RAM = 2'b01;
  localparam logic [2:0] EXT_B = 3'd0, EXT_BU = 3'd1, EXT_H = 3'd2, EXT_HU = 3'd3, EXT_W = 3'd4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_valid = 1'b0, da_rvalid = 1'b0, da_wdone = 1'b0;
  logic [1:0]  mem_wd_sel = '0;
  logic [31:0] mem_ram_addr = '0, da_rdata = '0;
  logic [2:0]  mem_ram_ext_op = '0;
  logic [3:0]  mem_ram_we = '0;
  logic        mem_stall, wb_valid, mem_ale, mem_timeout;
  logic [31:0] wb_rdata;

  logic [33:0] sb_q[$];
  int n_cmp = 0, n_err = 0;

  mem_resp #(.TO_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wd_sel(mem_wd_sel),
    .mem_ram_addr(mem_ram_addr), .mem_ram_ext_op(mem_ram_ext_op), .mem_ram_we(mem_ram_we),
    .da_rvalid(da_rvalid), .da_rdata(da_rdata), .da_wdone(da_wdone),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_rdata(wb_rdata),
    .mem_ale(mem_ale), .mem_timeout(mem_timeout));

  always #5 clk = ~clk;

  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    mem_valid = 1'b0; da_rvalid = 1'b0; da_wdone = 1'b0; da_rdata = '0;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [2:0] ext, input logic [3:0] we);
    mem_valid = 1'b1; mem_wd_sel = WD_RAM; mem_ram_addr = addr;
    mem_ram_ext_op = ext; mem_ram_we = we;
  endtask

  // Drives one access and returns when wb_valid is seen or maxc cycles elapse (lat = -1).
  task automatic run(input logic [31:0] addr, input logic [2:0] ext, input logic [3:0] we,
                     input int ack_at, input logic [31:0] data, input int maxc,
                     output int lat, output int stalls, output logic [33:0] obs);
    lat = -1; stalls = 0; obs = '0;
    go(); issue(addr, ext, we);
    for (int i = 0; i < maxc; i++) begin
      if (i == ack_at) begin
        if (we != 4'h0) da_wdone = 1'b1;
        else begin da_rvalid = 1'b1; da_rdata = data; end
      end
      @(negedge clk);
      if (mem_stall) stalls++;
      if (wb_valid) begin lat = i; obs = {mem_timeout, mem_ale, wb_rdata}; break; end
      go(); clr();
    end
  endtask

  task automatic test_reset();
    clr();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({mem_stall, wb_valid, mem_ale, mem_timeout, wb_rdata} !== 36'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0",
                        {mem_stall, wb_valid, mem_ale, mem_timeout, wb_rdata});
    end
    go(); rst = 1'b0;
  endtask

  task automatic test_loads();
    int lat, st; logic [33:0] obs, exp;
    // ld.b byte 3, ack three cycles after start
    sb_q.push_back({2'b00, 32'hFFFF_FF80});
    run(32'h1003, EXT_B, 4'h0, 3, 32'h80AA_BBCC, 20, lat, st, obs);
    exp = sb_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ld_b_data: got %h want %h", obs, exp); end
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL ld_b_latency: got %0d want 4", lat); end
    n_cmp++; if (st != 4) begin n_err++; $display("FAIL ld_b_stall: got %0d want 4", st); end
    go(); clr(); @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL ld_b_pulse: got %b want 0", wb_valid); end
    // ld.hu and ld.h, upper half
    sb_q.push_back({2'b00, 32'h0000_8001});
    run(32'h1002, EXT_HU, 4'h0, 1, 32'h8001_1234, 20, lat, st, obs);
    exp = sb_q.pop_front();
    n_cmp++; if (obs !== exp || lat != 2) begin
      n_err++; $display("FAIL ld_hu: got %h lat %0d want %h lat 2", obs, lat, exp); end
    sb_q.push_back({2'b00, 32'hFFFF_8001});
    run(32'h1002, EXT_H, 4'h0, 2, 32'h8001_1234, 20, lat, st, obs);
    exp = sb_q.pop_front();
    n_cmp++; if (obs !== exp || lat != 3 || st != 3) begin
      n_err++; $display("FAIL ld_h: got %h lat %0d stall %0d want %h lat 3 stall 3", obs, lat, st, exp); end
    // ld.bu byte 1, and an unknown extension code passing the word through
    sb_q.push_back({2'b00, 32'h0000_0056});
    run(32'h5001, EXT_BU, 4'h0, 1, 32'h1234_56F0, 20, lat, st, obs);
    exp = sb_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ld_bu: got %h want %h", obs, exp); end
    sb_q.push_back({2'b00, 32'hDEAD_BEEF});
    run(32'h5002, 3'd6, 4'h0, 1, 32'hDEAD_BEEF, 20, lat, st, obs);
    exp = sb_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ld_unknown_ext: got %h want %h", obs, exp); end
  endtask

  task automatic test_misaligned();
    int lat, st; logic [33:0] obs, exp;
    // ld.w off 1 with a spurious read ack in the ERR cycle
    sb_q.push_back({2'b01, 32'h0});
    run(32'h1001, EXT_W, 4'h0, 1, 32'h5555_5555, 20, lat, st, obs);
    exp = sb_q.pop_front();
    n_cmp++; if (obs !== exp || lat != 1) begin
      n_err++; $display("FAIL ale_ld_w: got %h lat %0d want %h lat 1", obs, lat, exp); end
    n_cmp++; if (st != 0) begin n_err++; $display("FAIL ale_stall: got %0d want 0", st); end
    go(); clr(); @(negedge clk);
    n_cmp++; if ({wb_valid, mem_ale, mem_stall} !== 3'b000) begin
      n_err++; $display("FAIL ale_after: got %b want 000", {wb_valid, mem_ale, mem_stall}); end
    // st.h odd address is misaligned; st.b odd address is fine
    sb_q.push_back({2'b01, 32'h0});
    run(32'h2001, EXT_B, 4'h3, -1, 32'h0, 20, lat, st, obs);
    exp = sb_q.pop_front();
    n_cmp++; if (obs !== exp || lat != 1) begin
      n_err++; $display("FAIL ale_st_h: got %h lat %0d want %h lat 1", obs, lat, exp); end
    sb_q.push_back({2'b00, 32'h0});
    run(32'h2003, EXT_B, 4'h1, 1, 32'h0, 20, lat, st, obs);
    exp = sb_q.pop_front();
    n_cmp++; if (obs !== exp || lat != 2) begin
      n_err++; $display("FAIL st_b_odd: got %h lat %0d want %h lat 2", obs, lat, exp); end
  endtask

  task automatic test_back_to_back();
    int hits[$]; logic [33:0] exp;
    go(); clr();
    sb_q.push_back({2'b00, 32'h0});
    sb_q.push_back({2'b00, 32'hCAFE_F00D});
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: issue(32'h2000, EXT_B, 4'hF);
        2: da_wdone = 1'b1;
        3: issue(32'h3004, EXT_W, 4'h0);
        4: da_wdone = 1'b1;
        5: begin da_rvalid = 1'b1; da_rdata = 32'hCAFE_F00D; end
        default: ;
      endcase
      @(negedge clk);
      if (i == 3) begin
        n_cmp++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall: got %b want 1", mem_stall); end
      end
      if (wb_valid) begin
        hits.push_back(i);
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL b2b_extra: got wb_valid at %0d want none", i);
        end else begin
          exp = sb_q.pop_front();
          n_cmp++;
          if ({mem_timeout, mem_ale, wb_rdata} !== exp) begin
            n_err++; $display("FAIL b2b_data: got %h want %h", {mem_timeout, mem_ale, wb_rdata}, exp); end
        end
      end
      go(); clr();
    end
    n_cmp++;
    if (hits.size() != 2 || hits[0] != 3 || hits[1] != 6) begin
      n_err++; $display("FAIL b2b_timing: got %0d pulses want 2 at cycles 3 and 6", hits.size());
    end
    sb_q.delete();
  endtask

  task automatic test_reset_mid();
    go(); clr(); issue(32'h3000, EXT_W, 4'h0);
    @(negedge clk); go(); clr(); @(negedge clk);
    n_cmp++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL rstmid_wait: got %b want 1", mem_stall); end
    go(); rst = 1'b1; @(negedge clk);
    n_cmp++;
    if ({mem_stall, wb_valid, mem_ale, mem_timeout, wb_rdata} !== 36'h0) begin
      n_err++; $display("FAIL rstmid_outputs: got %h want 0",
                        {mem_stall, wb_valid, mem_ale, mem_timeout, wb_rdata}); end
    go(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin da_rvalid = 1'b1; da_rdata = 32'h1111_2222; end
      @(negedge clk);
      n_cmp++;
      if ({wb_valid, mem_stall, mem_ale} !== 3'b000) begin
        n_err++; $display("FAIL rstmid_late_ack: got %b want 000 at %0d", {wb_valid, mem_stall, mem_ale}, i); end
      go(); clr();
    end
  endtask

  task automatic test_timeout();
    int lat, st; logic [33:0] obs, exp;
`ifdef MEM_RESP_TIMEOUT_EN
    sb_q.push_back({2'b10, 32'h0});
    run(32'h4000, EXT_W, 4'h0, -1, 32'h0, 20, lat, st, obs);
    exp = sb_q.pop_front();
    n_cmp++; if (obs !== exp || lat != 5) begin
      n_err++; $display("FAIL timeout_fire: got %h lat %0d want %h lat 5", obs, lat, exp); end
    go(); clr(); @(negedge clk);
    n_cmp++; if ({wb_valid, mem_timeout} !== 2'b00) begin
      n_err++; $display("FAIL timeout_pulse: got %b want 00", {wb_valid, mem_timeout}); end
    // ack in the last watchdog cycle wins
    sb_q.push_back({2'b00, 32'h1122_3344});
    run(32'h4004, EXT_W, 4'h0, 4, 32'h1122_3344, 20, lat, st, obs);
    exp = sb_q.pop_front();
    n_cmp++; if (obs !== exp || lat != 5) begin
      n_err++; $display("FAIL timeout_ack_wins: got %h lat %0d want %h lat 5", obs, lat, exp); end
`else
    run(32'h4000, EXT_W, 4'h0, -1, 32'h0, 1000, lat, st, obs);
    n_cmp++; if (lat != -1) begin n_err++; $display("FAIL no_timeout_wb: got lat %0d want none", lat); end
    n_cmp++; if (st != 1000) begin n_err++; $display("FAIL no_timeout_stall: got %0d want 1000", st); end
    n_cmp++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL no_timeout_flag: got %b want 0", mem_timeout); end
    go(); rst = 1'b1; go(); rst = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_loads();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "bench time limit");
  end
endmodule
